// File: rtl/four_12_12_pkg.sv
// Shared constants and state encoding for the four_12_12 stage-2 control slice.
package four_12_12_pkg;

    localparam int NUM_PHASES = 12;
    localparam int PIPE_DEPTH = 6;
    localparam int DATA_AW    = 10;
    localparam int TAP_AW     = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FWD    = 2'd1,
        UPDATE = 2'd2,
        DRAIN  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/four_12_12_delay_line.sv
// Fixed-latency shift register with synchronous active-high clear.
module four_12_12_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // NOTE: the stages are cleared on reset so an aborted frame cannot push stale valids out later.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/four_12_12_st2_seq_ctrl.sv
// Stage-2 frame sequencer: forward reads, optional error-update pass, pipeline drain.
// Next-cycle outputs are computed from the current state and registered with it.
module four_12_12_st2_seq_ctrl #(
    parameter int NUM_PHASES = four_12_12_pkg::NUM_PHASES,
    parameter int PIPE_DEPTH = four_12_12_pkg::PIPE_DEPTH,
    parameter int DATA_AW    = four_12_12_pkg::DATA_AW,
    parameter int TAP_AW     = four_12_12_pkg::TAP_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DATA_AW-1:0] data_base,
    input  logic               update_req,
    input  logic               stage_2_data_out_rdy,
    output logic               busy,
    output logic               done,
    output logic [TAP_AW-1:0]  tap_address,
    output logic [DATA_AW-1:0] data_read_addr,
    output logic               active_normal,
    output logic               active_start_d,
    output logic               active,
    output logic [3:0]         error_phase,
    output logic               error_update_first,
    output logic               error_update_latch,
    output logic               error_tap_update_out
);
    import four_12_12_pkg::*;

    localparam int CW = $clog2(NUM_PHASES + 1);
    localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_END    = CW'(NUM_PHASES);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_DEPTH - 1);

    seq_state_t         state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx, fwd_idx, upd_idx;
    logic [DW-1:0]      drain_cnt, drain_nx;
    logic [DATA_AW-1:0] base_r, base_nx, fwd_base, addr_nx;
    logic [TAP_AW-1:0]  tap_nx;
    logic [3:0]         phase_nx;
    logic               upd_pend, upd_pend_nx, fwd_issue, upd_issue;
    logic               busy_nx, done_nx, an_nx, start_d_nx, first_nx, latch_nx, tap_upd_nx;

    always_comb begin
        // NOTE: every signal takes a default first, so no branch can leave one unassigned.
        state_nx    = state;
        cnt_nx      = cnt;
        drain_nx    = drain_cnt;
        base_nx     = base_r;
        upd_pend_nx = upd_pend;
        fwd_issue   = 1'b0;
        fwd_idx     = cnt;
        fwd_base    = base_r;
        upd_issue   = 1'b0;
        upd_idx     = cnt;
        tap_nx      = tap_address;
        addr_nx     = data_read_addr;
        phase_nx    = error_phase;
        an_nx       = 1'b0;
        start_d_nx  = 1'b0;
        first_nx    = 1'b0;
        latch_nx    = 1'b0;
        tap_upd_nx  = 1'b0;

        case (state)
            IDLE: if (start) begin
                state_nx  = FWD;
                base_nx   = data_base;
                cnt_nx    = '0;
                fwd_issue = stage_2_data_out_rdy;
                fwd_idx   = '0;
                fwd_base  = data_base;
            end
            FWD: if (cnt == CNT_END) begin
                cnt_nx = '0;
                if (upd_pend) begin
                    state_nx    = UPDATE;
                    upd_pend_nx = 1'b0;
                    upd_issue   = 1'b1;
                    upd_idx     = '0;
                end else begin
                    state_nx = DRAIN;
                    drain_nx = '0;
                end
            end else begin
                fwd_issue = stage_2_data_out_rdy;
            end
            UPDATE: if (cnt == CNT_END) begin
                state_nx = DRAIN;
                drain_nx = '0;
            end else begin
                upd_issue = 1'b1;
            end
            DRAIN: if (drain_cnt == DRAIN_LAST) state_nx = IDLE;
                   else drain_nx = drain_cnt + 1'b1;
            default: state_nx = IDLE;
        endcase

        // A request arriving on the UPDATE-entry cycle survives the clear above.
        if (update_req) upd_pend_nx = 1'b1;

        if (fwd_issue) begin
            an_nx      = 1'b1;
            start_d_nx = (fwd_idx == '0);
            tap_nx     = TAP_AW'(fwd_idx);
            addr_nx    = fwd_base + DATA_AW'(fwd_idx);
            cnt_nx     = fwd_idx + 1'b1;
        end
        if (upd_issue) begin
            an_nx      = 1'b1;
            first_nx   = (upd_idx == '0);
            latch_nx   = 1'b1;
            tap_upd_nx = 1'b1;
            tap_nx     = TAP_AW'(NUM_PHASES) + TAP_AW'(upd_idx);
            phase_nx   = 4'(upd_idx);
            cnt_nx     = upd_idx + 1'b1;
        end

        done_nx = (state_nx == DRAIN) && (drain_nx == DRAIN_LAST);
        busy_nx = (state_nx != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            cnt                  <= '0;
            drain_cnt            <= '0;
            base_r               <= '0;
            upd_pend             <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            tap_address          <= '0;
            data_read_addr       <= '0;
            active_normal        <= 1'b0;
            active_start_d       <= 1'b0;
            error_phase          <= '0;
            error_update_first   <= 1'b0;
            error_update_latch   <= 1'b0;
            error_tap_update_out <= 1'b0;
        end else begin
            state                <= state_nx;
            cnt                  <= cnt_nx;
            drain_cnt            <= drain_nx;
            base_r               <= base_nx;
            upd_pend             <= upd_pend_nx;
            busy                 <= busy_nx;
            done                 <= done_nx;
            tap_address          <= tap_nx;
            data_read_addr       <= addr_nx;
            active_normal        <= an_nx;
            active_start_d       <= start_d_nx;
            error_phase          <= phase_nx;
            error_update_first   <= first_nx;
            error_update_latch   <= latch_nx;
            error_tap_update_out <= tap_upd_nx;
        end
    end

    four_12_12_delay_line #(
        .WIDTH (1),
        .DEPTH (PIPE_DEPTH)
    ) u_active_dly (
        .clk   (clk),
        .reset (reset),
        .din   (active_normal),
        .dout  (active)
    );

endmodule

// File: tb/tb_four_12_12_st2_seq_ctrl.sv
// Scoreboard bench for the stage-2 frame sequencer: a per-cycle timeline model
// fills a queue of expected outputs that is drained as the DUT runs.
module tb_four_12_12_st2_seq_ctrl;
    import four_12_12_pkg::*;

    localparam int NP = NUM_PHASES;
    localparam int PD = PIPE_DEPTH;

    typedef struct packed {
        logic               busy;
        logic               done;
        logic               an;
        logic               start_d;
        logic               act;
        logic               first;
        logic               latch;
        logic               tap_upd;
        logic [3:0]         phase;
        logic [TAP_AW-1:0]  tap;
        logic [DATA_AW-1:0] addr;
    } obs_t;

    logic               clk, reset, start, update_req, stage_2_data_out_rdy;
    logic [DATA_AW-1:0] data_base;
    logic               busy, done, active_normal, active_start_d, active;
    logic               error_update_first, error_update_latch, error_tap_update_out;
    logic [TAP_AW-1:0]  tap_address;
    logic [DATA_AW-1:0] data_read_addr;
    logic [3:0]         error_phase;

    obs_t               exp_q[$];
    obs_t               got, want;
    int                 vectors, miscompares;
    logic [TAP_AW-1:0]  last_tap;
    logic [DATA_AW-1:0] last_addr;
    logic [3:0]         last_phase;

    four_12_12_st2_seq_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .data_base            (data_base),
        .update_req           (update_req),
        .stage_2_data_out_rdy (stage_2_data_out_rdy),
        .busy                 (busy),
        .done                 (done),
        .tap_address          (tap_address),
        .data_read_addr       (data_read_addr),
        .active_normal        (active_normal),
        .active_start_d       (active_start_d),
        .active               (active),
        .error_phase          (error_phase),
        .error_update_first   (error_update_first),
        .error_update_latch   (error_update_latch),
        .error_tap_update_out (error_tap_update_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic obs_t sample();
        obs_t o;
        o.busy = busy; o.done = done; o.an = active_normal; o.start_d = active_start_d;
        o.act = active; o.first = error_update_first; o.latch = error_update_latch;
        o.tap_upd = error_tap_update_out; o.phase = error_phase;
        o.tap = tap_address; o.addr = data_read_addr;
        return o;
    endfunction

    function automatic obs_t next_want();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    // Idle cycles: strobes low, address-type outputs hold their last values.
    task automatic push_idle(input int n);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.tap = last_tap; e.addr = last_addr; e.phase = last_phase;
            exp_q.push_back(e);
        end
    endtask

    // Expected outputs for frame cycles 1..len after a start accepted at cycle 0.
    task automatic push_frame(input logic [DATA_AW-1:0] base, input logic [63:0] stall,
                              input bit upd, output int len);
        obs_t e [64];
        int   c, k;
        for (int i = 0; i < 64; i++) e[i] = '0;
        c = 1;
        k = 0;
        while (k < NP) begin
            e[c].busy = 1'b1;
            if (!stall[c]) begin
                e[c].an      = 1'b1;
                e[c].start_d = (k == 0);
                last_tap     = TAP_AW'(k);
                last_addr    = base + DATA_AW'(k);
                k++;
            end
            e[c].tap = last_tap; e[c].addr = last_addr; e[c].phase = last_phase;
            c++;
        end
        if (upd) begin
            for (int p = 0; p < NP; p++) begin
                e[c].busy = 1'b1; e[c].an = 1'b1; e[c].latch = 1'b1;
                e[c].tap_upd = 1'b1; e[c].first = (p == 0);
                last_phase = 4'(p);
                last_tap   = TAP_AW'(NP + p);
                e[c].tap = last_tap; e[c].addr = last_addr; e[c].phase = last_phase;
                c++;
            end
        end
        for (int d = 0; d < PD; d++) begin
            e[c].busy = 1'b1;
            e[c].done = (d == PD - 1);
            e[c].tap = last_tap; e[c].addr = last_addr; e[c].phase = last_phase;
            c++;
        end
        len = c - 1;
        for (int i = 1; i <= len; i++) begin
            if (i > PD) e[i].act = e[i-PD].an;
            exp_q.push_back(e[i]);
        end
    endtask

    task automatic drive(input logic s, input logic [DATA_AW-1:0] b, input logic r,
                         input logic u, input logic rs);
        start = s; data_base = b; stage_2_data_out_rdy = r; update_req = u; reset = rs;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        push_idle(1);
        got = sample(); want = next_want(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_held: got %h want %h", got, want);
        end
        reset = 1'b0;
        @(negedge clk);
        push_idle(1);
        got = sample(); want = next_want(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_release: got %h want %h", got, want);
        end
    endtask

    // Basic frame plus a stray start in FWD that must not queue a second frame.
    task automatic test_basic();
        int len;
        push_idle(1);
        push_frame(10'h010, 64'd0, 1'b0, len);
        push_idle(3);
        for (int c = 0; c <= len + 3; c++) begin
            got = sample(); want = next_want(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL basic cycle %0d: got %h want %h", c, got, want);
            end
            drive(c == 0 || c == 5, 10'h010, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        int len;
        push_idle(1);
        push_frame(10'h3FA, 64'd0, 1'b0, len);
        push_idle(1);
        for (int c = 0; c <= len + 1; c++) begin
            got = sample(); want = next_want(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL wrap cycle %0d: got %h want %h", c, got, want);
            end
            drive(c == 0, 10'h3FA, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    // Ready is low on the edges that produce output cycles 3 and 4.
    task automatic test_stall();
        int          len;
        logic [63:0] stall;
        stall = 64'd0;
        stall[3] = 1'b1;
        stall[4] = 1'b1;
        push_idle(1);
        push_frame(10'h0A0, stall, 1'b0, len);
        push_idle(1);
        for (int c = 0; c <= len + 1; c++) begin
            got = sample(); want = next_want(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL stall cycle %0d: got %h want %h", c, got, want);
            end
            drive(c == 0, 10'h0A0, !stall[c+1], 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    // Start held high: ignored while busy, accepted again on the first IDLE cycle.
    task automatic test_back_to_back();
        int len1, len2;
        push_idle(1);
        push_frame(10'h123, 64'd0, 1'b0, len1);
        push_idle(1);
        push_frame(10'h200, 64'd0, 1'b0, len2);
        push_idle(1);
        for (int c = 0; c <= len1 + len2 + 2; c++) begin
            got = sample(); want = next_want(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", c, got, want);
            end
            drive(c <= len1 + 1, (c > len1) ? 10'h200 : 10'h123, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_update();
        int len;
        push_idle(2);
        push_frame(10'h040, 64'd0, 1'b1, len);
        push_idle(1);
        for (int c = -1; c <= len + 1; c++) begin
            got = sample(); want = next_want(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL update cycle %0d: got %h want %h", c, got, want);
            end
            drive(c == 0, 10'h040, 1'b1, c == -1, 1'b0);
            @(negedge clk);
        end
    endtask

    // Request lands on the edge that enters UPDATE; the following frame must update too.
    task automatic test_collision();
        int len1, len2;
        push_idle(2);
        push_frame(10'h300, 64'd0, 1'b1, len1);
        push_idle(1);
        push_frame(10'h310, 64'd0, 1'b1, len2);
        push_idle(1);
        for (int c = -1; c <= len1 + len2 + 2; c++) begin
            got = sample(); want = next_want(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL collision cycle %0d: got %h want %h", c, got, want);
            end
            drive(c == 0 || c == len1 + 1, (c > len1) ? 10'h310 : 10'h300, 1'b1,
                  c == -1 || c == NP, 1'b0);
            @(negedge clk);
        end
    endtask

    // Reset during UPDATE: outputs clear at once, no done, pending request dropped.
    task automatic test_reset_abort();
        int len, len2;
        push_idle(1);
        push_frame(10'h155, 64'd0, 1'b1, len);
        while (exp_q.size() > 16) void'(exp_q.pop_back());
        last_tap = '0; last_addr = '0; last_phase = '0;
        push_idle(4);
        push_frame(10'h100, 64'd0, 1'b0, len2);
        push_idle(1);
        for (int c = 0; c <= 20 + len2 - 1; c++) begin
            got = sample(); want = next_want(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_abort cycle %0d: got %h want %h", c, got, want);
            end
            drive(c == 0 || c == 5 || c == 19, (c >= 19) ? 10'h100 : 10'h155, 1'b1,
                  c == 3 || c == 14, c == 15);
            @(negedge clk);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_tap    = '0;
        last_addr   = '0;
        last_phase  = '0;
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_update();
        test_collision();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/four_12_12_st2_seq_ctrl.md
# four_12_12_st2_seq_ctrl

Frame sequencer for the four_12_12 stage-2 datapath. Per frame it issues 12 forward tap/data reads, optionally 12 error-update tap accesses, then drains the pipeline. It drives the control inputs of the stage-2 output controller: tap_address, data_read_addr, active_normal, active_start_d, active, error_phase and the error-update strobes. It sits between the network-level scheduler (start/update_req/done) and the stage-2 memories.

## Interface
Parameters:
- NUM_PHASES, 12, forward reads per frame; also the number of update phases.
- PIPE_DEPTH, 6, cycles from a tap read to a valid stage output.
- DATA_AW, 10, data memory address width.
- TAP_AW, 5, tap memory address width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; all state and outputs cleared.
- start  in  1  frame request; accepted only in IDLE.
- data_base  in  DATA_AW  first data read address, sampled with an accepted start.
- update_req  in  1  pulse; an error-update pass is requested for the next frame.
- stage_2_data_out_rdy  in  1  downstream ready; low stalls forward reads.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the last DRAIN cycle.
- tap_address  out  TAP_AW  tap/bias read row.
- data_read_addr  out  DATA_AW  data read address.
- active_normal  out  1  read-valid strobe.
- active_start_d  out  1  first forward read of the frame.
- active  out  1  active_normal delayed PIPE_DEPTH cycles.
- error_phase  out  4  update phase 0..NUM_PHASES-1.
- error_update_first  out  1  first update cycle.
- error_update_latch  out  1  every update cycle.
- error_tap_update_out  out  1  high throughout UPDATE.

## Operation
- States: IDLE, FWD, UPDATE, DRAIN. All outputs are registered. Every output resets to 0.
- IDLE -> FWD on start. base_r is loaded with data_base; phase_cnt and addr_cnt are cleared.
- FWD, cycle with rdy=1:
  - active_normal=1, tap_address=phase_cnt, data_read_addr=base_r+addr_cnt (mod 2^DATA_AW, wraps).
  - Both counters increment.
  - active_start_d=1 only when phase_cnt=0.
- FWD, cycle with rdy=0: counters hold and active_normal=0. The bubble propagates to active.
- FWD exit, after the read with phase_cnt=NUM_PHASES-1:
  - To UPDATE if upd_pend=1, otherwise to DRAIN.
  - upd_pend is cleared on entering UPDATE.
- UPDATE, NUM_PHASES cycles with no stall:
  - tap_address=NUM_PHASES+error_phase, error_phase counts 0..11.
  - error_update_latch=1 and error_tap_update_out=1 on every cycle; error_update_first=1 only at phase 0.
  - active_normal=1.
  - Then go to DRAIN.
- DRAIN: lasts exactly PIPE_DEPTH cycles (drain counter). done=1 on the last cycle, then IDLE.
- upd_pend:
  - Set by update_req in any state.
  - If a set and the UPDATE-entry clear happen in the same cycle, the set wins and the request stays pending for the next frame.
- start outside IDLE is ignored (not queued).
- reset mid-frame:
  - Next cycle is IDLE; all outputs and upd_pend are 0; the active delay line is flushed.
  - No done is issued for the aborted frame.

## Timing
- start sampled at cycle 0, no stalls, upd_pend=0:
  - FWD occupies cycles 1..12; active_start_d is high at cycle 1.
  - active is high at cycles 7..18.
  - DRAIN occupies cycles 13..18, with done at cycle 18.
  - busy is high over cycles 1..18; the earliest next start is accepted at cycle 19.
- With upd_pend=1:
  - UPDATE occupies cycles 13..24, with error_update_first at cycle 13.
  - DRAIN occupies cycles 25..30, with done at cycle 30.
- Each rdy=0 cycle in FWD extends FWD and all later events by one cycle. rdy is ignored in UPDATE and DRAIN.
- Latency from active_normal to active is exactly PIPE_DEPTH cycles, stall bubbles included.

## Structure
- Shared package four_12_12_pkg holds:
  - the NUM_PHASES, PIPE_DEPTH, DATA_AW and TAP_AW constants;
  - the state enum seq_state_t {IDLE, FWD, UPDATE, DRAIN}.
- One sub-module, four_12_12_delay_line (WIDTH, DEPTH, sync reset), implements the active delay.

## Test plan
- Basic frame: start with data_base=0x010 and no stalls -> data_read_addr 0x010..0x01B at cycles 1..12; tap_address 0..11; active 7..18; done at cycle 18.
- Wrap-around: data_base=0x3FA -> addresses 0x3FA..0x3FF, then 0x000..0x005.
- Stall: rdy=0 at cycles 3-4 -> addresses hold; active_normal low at cycles 3-4; active low at cycles 9-10; done at cycle 20.
- Update pass: update_req pulsed before the frame -> tap_address 12..23 with error_phase 0..11 at cycles 13..24; error_update_first only at cycle 13; done at cycle 30.
- Request collision: update_req on the UPDATE-entry cycle -> the next frame also runs UPDATE.
- Reset and ignored start: start while busy is ignored; reset at cycle 15 -> IDLE at cycle 16, all outputs 0, active stays 0, no done.
